// File: rtl/sramlike_mem_resp.sv
// rtl/sramlike_mem_resp.sv - SRAM-like memory responder with programmable addr/data handshake latency
module sramlike_mem_resp #(
    parameter int MEM_INDEX_WIDTH = 10,
    parameter int ADDR_DELAY      = 1,
    parameter int DATA_DELAY      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok
);

    localparam int A_INIT = (ADDR_DELAY > 0) ? ADDR_DELAY - 1 : 0;
    localparam int D_INIT = (DATA_DELAY > 0) ? DATA_DELAY - 1 : 0;
    localparam int AW     = MEM_INDEX_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, AWAIT, DWAIT} state_t;

    state_t          state_q, state_d;
    logic [3:0]      acnt_q, acnt_d;
    logic [3:0]      dcnt_q, dcnt_d;
    logic            wr_q, wr_d;
    logic [1:0]      size_q, size_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0]     mem [0:(1 << MEM_INDEX_WIDTH) - 1];
    logic [MEM_INDEX_WIDTH-1:0] idx;
    logic [31:0]     rd_word;
    logic [3:0]      be;
    logic            mem_we;
    logic            unused_addr_hi;

    assign unused_addr_hi = ^addr[31:AW];
    assign idx            = addr_q[AW-1:2];
    assign rd_word        = mem[idx];

    always_comb begin
        be = 4'b1111;
        case (size_q)
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acnt_d  = acnt_q;
        dcnt_d  = dcnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (ADDR_DELAY == 0) begin
                        addr_ok = 1'b1;
                        state_d = DWAIT;
                    end else begin
                        acnt_d  = 4'(A_INIT);
                        state_d = AWAIT;
                    end
                end
            end
            AWAIT: begin
                if (!req) begin
                    acnt_d  = 4'd0;
                    state_d = IDLE;
                end else if (acnt_q == 4'd0) begin
                    addr_ok = 1'b1;
                    state_d = DWAIT;
                end else begin
                    acnt_d = acnt_q - 4'd1;
                end
            end
            DWAIT: begin
                if (dcnt_q == 4'd0) begin
                    data_ok = 1'b1;
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs must drop as soon as reset rises, before the state register clears.
        if (rst) begin
            addr_ok = 1'b0;
            data_ok = 1'b0;
        end
        if (addr_ok) begin
            wr_d    = wr;
            size_d  = size;
            addr_d  = addr[AW-1:0];
            wdata_d = wdata;
            dcnt_d  = 4'(D_INIT);
        end
    end

    assign mem_we  = data_ok && wr_q;
    assign rdata_d = (data_ok && !wr_q) ? rd_word : rdata_q;
    assign rdata   = rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acnt_q  <= 4'd0;
            dcnt_q  <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            acnt_q  <= acnt_d;
            dcnt_q  <= dcnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Backing store keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sramlike_mem_resp.sv
// tb/tb_sramlike_mem_resp.sv - self-checking bench for sramlike_mem_resp (default and zero-delay instances)
module tb_sramlike_mem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_s   [2];
    logic        wr_s    [2];
    logic [1:0]  size_s  [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        aok     [2];
    logic        dok     [2];

    int total = 0;
    int bad   = 0;
    int ad_c [2];
    int dd_c [2];

    logic [31:0] mdl  [2][1024];
    bit          mval [2][1024];

    typedef struct {
        int          inst;
        bit          w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [$];

    always #5 clk = ~clk;

    sramlike_mem_resp u0 (
        .clk(clk), .rst(rst), .req(req_s[0]), .wr(wr_s[0]), .size(size_s[0]),
        .addr(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]),
        .addr_ok(aok[0]), .data_ok(dok[0])
    );

    sramlike_mem_resp #(.MEM_INDEX_WIDTH(10), .ADDR_DELAY(0), .DATA_DELAY(1)) u1 (
        .clk(clk), .rst(rst), .req(req_s[1]), .wr(wr_s[1]), .size(size_s[1]),
        .addr(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]),
        .addr_ok(aok[1]), .data_ok(dok[1])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference write: each byte lane named by the access size/offset takes the matching wdata lane.
    task automatic model_write(input int i, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int idx;
        int first;
        int nbytes;
        idx    = int'(a[11:2]);
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        first  = (nbytes == 4) ? 0 : (int'(a[1:0]) / nbytes) * nbytes;
        for (int b = first; b < first + nbytes; b++) mdl[i][idx][8*b +: 8] = d[8*b +: 8];
        if (nbytes == 4) mval[i][idx] = 1'b1;
    endtask

    task automatic scramble(input int i);
        wr_s[i]    = 1'($urandom);
        size_s[i]  = 2'($urandom);
        addr_s[i]  = $urandom;
        wdata_s[i] = $urandom;
    endtask

    task automatic txn(input int i, input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd);
        int n;
        bit got;
        rd = 32'hx;
        req_s[i] = 1'b1; wr_s[i] = w; size_s[i] = sz; addr_s[i] = a; wdata_s[i] = d;
        n = 0; got = 0;
        while (!got && n <= 40) begin
            @(negedge clk);
            if (aok[i]) got = 1; else n++;
        end
        check("addr_ok_latency", n, ad_c[i]);
        if (!got) begin
            req_s[i] = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        req_s[i] = 1'b0;
        scramble(i);
        n = 0; got = 0;
        while (!got && n <= 40) begin
            @(negedge clk);
            n++;
            if (dok[i]) got = 1;
        end
        check("data_ok_latency", n, dd_c[i]);
        rd = rdata_s[i];
        if (got && w) model_write(i, sz, a, d);
        @(posedge clk); #1;
        check("data_ok_pulse", 32'(dok[i]), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        ad_c[0] = 1; dd_c[0] = 2;
        ad_c[1] = 0; dd_c[1] = 1;
        for (int i = 0; i < 2; i++) begin
            req_s[i] = 1'b0; wr_s[i] = 1'b0; size_s[i] = 2'b10; addr_s[i] = 32'h0; wdata_s[i] = 32'h0;
            for (int k = 0; k < 1024; k++) mval[i][k] = 1'b0;
        end

        // Reset state; req on the zero-delay instance must not leak an addr_ok.
        req_s[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_addr_ok", 32'(aok[i]), 32'h0);
            check("rst_data_ok", 32'(dok[i]), 32'h0);
            check("rst_rdata", rdata_s[i], 32'h0);
        end
        req_s[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        tbl.push_back('{0, 1'b1, 2'b10, 32'h0000_0010, 32'hDEADBEEF, 32'h0});
        tbl.push_back('{0, 1'b0, 2'b10, 32'h0000_0010, 32'h0,        32'hDEADBEEF});
        tbl.push_back('{0, 1'b1, 2'b10, 32'h0000_0020, 32'h11223344, 32'h0});
        tbl.push_back('{0, 1'b1, 2'b00, 32'h0000_0021, 32'hAAAAAAAA, 32'h0});
        tbl.push_back('{0, 1'b0, 2'b10, 32'h0000_0020, 32'h0,        32'h1122AA44});
        tbl.push_back('{0, 1'b1, 2'b01, 32'h0000_0022, 32'hBBCCBBCC, 32'h0});
        tbl.push_back('{0, 1'b0, 2'b10, 32'h0000_0020, 32'h0,        32'hBBCCAA44});
        tbl.push_back('{0, 1'b1, 2'b00, 32'h0000_0023, 32'h99999999, 32'h0});
        tbl.push_back('{0, 1'b1, 2'b01, 32'h0000_0021, 32'h77667766, 32'h0});
        tbl.push_back('{0, 1'b0, 2'b00, 32'h0000_0022, 32'h0,        32'h99CC7766});
        tbl.push_back('{0, 1'b1, 2'b11, 32'h0000_0004, 32'hCAFEF00D, 32'h0});
        tbl.push_back('{0, 1'b0, 2'b10, 32'h0000_1004, 32'h0,        32'hCAFEF00D});
        tbl.push_back('{1, 1'b1, 2'b10, 32'h0000_0008, 32'h12345678, 32'h0});
        tbl.push_back('{1, 1'b1, 2'b10, 32'hF000_000C, 32'h0BADF00D, 32'h0});
        tbl.push_back('{1, 1'b0, 2'b10, 32'h0000_000C, 32'h0,        32'h0BADF00D});
        foreach (tbl[t]) begin
            txn(tbl[t].inst, tbl[t].w, tbl[t].sz, tbl[t].a, tbl[t].d, rd);
            if (!tbl[t].w) check($sformatf("vec%0d_rdata", t), rd, tbl[t].exp);
        end

        // Request withdrawn during AWAIT: no handshake, memory untouched.
        req_s[0] = 1'b1; wr_s[0] = 1'b1; size_s[0] = 2'b10; addr_s[0] = 32'h10; wdata_s[0] = 32'h12121212;
        @(negedge clk);
        check("await_no_addr_ok", 32'(aok[0]), 32'h0);
        @(posedge clk); #1;
        req_s[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_quiet", {30'h0, aok[0], dok[0]}, 32'h0);
        end
        @(posedge clk); #1;
        txn(0, 1'b0, 2'b10, 32'h10, 32'h0, rd);
        check("abort_mem_kept", rd, 32'hDEADBEEF);

        // Reset during the data_ok cycle of a write must suppress it.
        txn(0, 1'b1, 2'b10, 32'h40, 32'h0, rd);
        txn(0, 1'b0, 2'b10, 32'h10, 32'h0, rd);
        req_s[0] = 1'b1; wr_s[0] = 1'b1; size_s[0] = 2'b10; addr_s[0] = 32'h40; wdata_s[0] = 32'h55555555;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_seq_addr_ok", 32'(aok[0]), 32'h1);
        @(posedge clk); #1;
        req_s[0] = 1'b0;
        @(posedge clk); #1;
        check("rst_seq_data_ok_pre", 32'(dok[0]), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_async_data_ok", 32'(dok[0]), 32'h0);
        check("rst_async_addr_ok", 32'(aok[0]), 32'h0);
        check("rst_async_rdata", rdata_s[0], 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        txn(0, 1'b0, 2'b10, 32'h40, 32'h0, rd);
        check("rst_no_write", rd, 32'h0);

        // Back-to-back reads with req held high on the zero-delay instance.
        req_s[1] = 1'b1; wr_s[1] = 1'b0; size_s[1] = 2'b10; addr_s[1] = 32'h8;
        @(negedge clk);
        check("b2b_c0", {30'h0, aok[1], dok[1]}, 32'h2);
        @(posedge clk); #1;
        addr_s[1] = 32'hC;
        @(negedge clk);
        check("b2b_c1", {30'h0, aok[1], dok[1]}, 32'h1);
        check("b2b_rd0", rdata_s[1], 32'h12345678);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_c2", {30'h0, aok[1], dok[1]}, 32'h2);
        @(posedge clk); #1;
        req_s[1] = 1'b0;
        @(negedge clk);
        check("b2b_c3", {30'h0, aok[1], dok[1]}, 32'h1);
        check("b2b_rd1", rdata_s[1], 32'h0BADF00D);
        @(posedge clk); #1;

        // Randomized traffic against the reference model in a preloaded region.
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 16; k++)
                txn(i, 1'b1, 2'b10, 32'h400 + 32'(k * 4), $urandom, rd);
        for (int t = 0; t < 200; t++) begin
            int          i;
            bit          w;
            logic [1:0]  sz;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] expw;
            i  = int'($urandom_range(1, 0));
            w  = 1'($urandom);
            sz = 2'($urandom);
            a  = ($urandom & 32'hFFFF_F000) | 32'h400 | 32'($urandom_range(63, 0));
            d  = $urandom;
            expw = mdl[i][a[11:2]];
            txn(i, w, sz, a, d, rd);
            if (!w) check($sformatf("rand%0d_rdata", t), rd, expw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
